uart_cmd_comm_param: RTL and testbench
======================================

Name: uart_cmd_comm_param

Overview:
Parametrised UART command/response channel, successor to the fixed 3-byte UART command block. RX side assembles NUM_CMD_BYTES serial bytes (MSB byte first) into one command word with a ready/clear handshake. TX side serialises a NUM_RSP_BYTES response word on one request. New over the previous block: generic byte counts, inter-byte timeout resync, and framing and overrun error reporting. Sits between the serial pins and the command-processing FSM.

Parameters:
CLK_DIV, 2604, clocks per bit; minimum 4, even.
NUM_CMD_BYTES, 3, bytes per received command; minimum 1.
NUM_RSP_BYTES, 1, bytes per transmitted response; minimum 1.
TIMEOUT_BAUDS, 16, idle bit-times tolerated between bytes of one command.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
RX  in  1  serial input, asynchronous, idle high
TX  out  1  serial output, idle high
clr_cmd_rdy  in  1  clears cmd_rdy
cmd_rdy  out  1  complete command held in cmd
cmd  out  8*NUM_CMD_BYTES  last complete command; first byte received lands in the MSBs
snd_rsp  in  1  1-cycle request to transmit rsp
rsp  in  8*NUM_RSP_BYTES  response word; MSB byte is sent first
tx_busy  out  1  transmitter active
rsp_done  out  1  1-cycle pulse when the last stop bit of a response ends
frm_err  out  1  1-cycle pulse on a bad stop bit
ovr_err  out  1  1-cycle pulse when a command is dropped because cmd_rdy is still set
rx_resync  out  1  1-cycle pulse when a partial command is discarded by timeout

Behaviour:
- Reset (async assert, sync release):
  - TX=1; cmd=0; all flags 0; byte counters 0; both FSMs IDLE.
  - After reset the RX FSM arms only once the synchronised RX has been seen high for at least 1 clock.
- RX input: RX passes through a 2-flop synchroniser. A start is a falling edge on the synchronised RX.
- RX FSM, states IDLE, START, DATA, STOP:
  - START: wait CLK_DIV/2 clocks, then sample. If the line is high, treat it as a glitch and return to IDLE with no flag.
  - DATA: 8 samples spaced CLK_DIV apart, LSB first.
  - STOP: sample once after CLK_DIV.
- Stop bit = 1:
  - Byte goes into the shadow register at slot (NUM_CMD_BYTES-1-idx); idx increments.
  - When idx reaches NUM_CMD_BYTES: idx=0. If cmd_rdy=0, or clr_cmd_rdy is asserted that same cycle, then cmd<=shadow and cmd_rdy<=1 on the next edge. Otherwise the new command is dropped, cmd holds its value, and ovr_err pulses.
- Stop bit = 0: frm_err pulses, the byte is discarded, and idx=0 (partial command discarded). The FSM returns to IDLE and re-arms only once the line is high.
- cmd changes only on a completion edge, never while a command is assembling.
- Timeout:
  - Applies while idx != 0 and the RX FSM is IDLE.
  - An idle counter counts clocks. At TIMEOUT_BAUDS*CLK_DIV clocks: idx=0 and rx_resync pulses once.
  - The counter clears on any start detect.
- clr_cmd_rdy: clears cmd_rdy on the next edge unless a completion occurs in the same cycle; completion wins.
- TX FSM, states IDLE, START, DATA, STOP:
  - In IDLE, snd_rsp latches rsp, sets tx_busy on the next edge, and sets byte idx=0.
  - Each bit lasts exactly CLK_DIV clocks; data goes LSB first.
  - Bytes go back-to-back: the next start bit follows the stop bit immediately.
  - After the last stop bit: tx_busy=0 and rsp_done pulses in the same cycle.
  - Total frame = 10*NUM_RSP_BYTES*CLK_DIV clocks from the first TX low.
  - snd_rsp while tx_busy=1 is ignored. rsp may change after the latch cycle.
- TX is registered with no combinational glitches. RX and TX operate fully independently; loopback (TX tied to RX) is legal.
- Reset mid-frame: TX goes to 1 immediately and no rsp_done is issued. A partial RX command is lost and cmd returns to 0.

Test Plan:
1. Loopback, CLK_DIV=16, 3/3 bytes: snd_rsp with rsp=24'h000000, then (after clr) 24'h123456 -> cmd=24'h000000 then 24'h123456; cmd_rdy=1 each time; rsp_done exactly 480 clocks after the first TX low; tx_busy low afterwards.
2. Overrun: send 0xA5,0xB6,0xC7 with no clear, then 0x01,0x02,0x03 -> ovr_err single pulse; cmd stays 24'hA5B6C7. Pulse clr_cmd_rdy, resend 010203 -> cmd=24'h010203, no ovr_err.
3. Framing: drive 0x55 with stop=0 -> frm_err pulse, no cmd_rdy. Then send 0x11,0x22,0x33 -> cmd=24'h112233.
4. Timeout: send 0xDE,0xAD, idle 20 bit-times, then send 0x11,0x22,0x33 -> rx_resync exactly one pulse; cmd=24'h112233.
5. Edge cases:
   - Glitch low for CLK_DIV/4 -> no byte received.
   - clr_cmd_rdy in the same cycle as completion -> cmd_rdy stays 1, cmd updated, no ovr_err.
   - snd_rsp while busy -> ignored; only one rsp_done.
   - NUM_CMD_BYTES=1 build -> cmd_rdy after every byte.
6. Reset: assert rst during the 2nd TX byte and mid-RX command -> TX=1, tx_busy=0, cmd=0, cmd_rdy=0, no rsp_done. After release, a fresh 24'h123456 loopback passes.

Source files
------------

// File: rtl/uart_cmd_comm_param.sv
// UART command/response channel: assembles NUM_CMD_BYTES serial bytes into one command word
// and serialises an NUM_RSP_BYTES response word, with timeout resync and error pulses.
module uart_cmd_comm_param #(
   parameter int unsigned CLK_DIV       = 2604,
   parameter int unsigned NUM_CMD_BYTES = 3,
   parameter int unsigned NUM_RSP_BYTES = 1,
   parameter int unsigned TIMEOUT_BAUDS = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       RX,
   output logic                       TX,
   input  logic                       clr_cmd_rdy,
   output logic                       cmd_rdy,
   output logic [8*NUM_CMD_BYTES-1:0] cmd,
   input  logic                       snd_rsp,
   input  logic [8*NUM_RSP_BYTES-1:0] rsp,
   output logic                       tx_busy,
   output logic                       rsp_done,
   output logic                       frm_err,
   output logic                       ovr_err,
   output logic                       rx_resync
);

   localparam int unsigned CMD_W   = 8*NUM_CMD_BYTES;
   localparam int unsigned RSP_W   = 8*NUM_RSP_BYTES;
   localparam int unsigned HALF    = CLK_DIV/2;
   localparam int unsigned TO_CLKS = TIMEOUT_BAUDS*CLK_DIV;
   localparam int unsigned CNT_W   = $clog2(CLK_DIV);
   localparam int unsigned TO_W    = $clog2(TO_CLKS+1);
   localparam int unsigned CIDX_W  = $clog2(NUM_CMD_BYTES+1);
   localparam int unsigned RIDX_W  = $clog2(NUM_RSP_BYTES+1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic              rx_s1, rx_s2, rx_prev;
   logic              rx_fall;
   state_t            rx_state;
   logic [CNT_W-1:0]  rx_cnt;
   logic [2:0]        rx_bit;
   logic [7:0]        rx_sr;
   logic [CIDX_W-1:0] rx_idx;
   logic [TO_W-1:0]   idle_cnt;
   logic [CMD_W-1:0]  shadow, shadow_nxt;

   // Sync flops reset low so a start needs the line to be seen high first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1   <= 1'b0;
         rx_s2   <= 1'b0;
         rx_prev <= 1'b0;
      end else begin
         rx_s1   <= RX;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign rx_fall = rx_prev & ~rx_s2;

   // Bytes shift in at the bottom, so after a full command the first byte sits in the MSBs.
   assign shadow_nxt = CMD_W'({shadow, rx_sr});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state  <= IDLE;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_sr     <= '0;
         rx_idx    <= '0;
         idle_cnt  <= '0;
         shadow    <= '0;
         cmd       <= '0;
         cmd_rdy   <= 1'b0;
         frm_err   <= 1'b0;
         ovr_err   <= 1'b0;
         rx_resync <= 1'b0;
      end else begin
         frm_err   <= 1'b0;
         ovr_err   <= 1'b0;
         rx_resync <= 1'b0;
         if (clr_cmd_rdy) cmd_rdy <= 1'b0;
         case (rx_state)
            IDLE: begin
               if (rx_fall) begin
                  rx_state <= START;
                  rx_cnt   <= '0;
                  idle_cnt <= '0;
               end else if (rx_idx != '0) begin
                  if (idle_cnt == TO_W'(TO_CLKS-1)) begin
                     rx_idx    <= '0;
                     rx_resync <= 1'b1;
                     idle_cnt  <= '0;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end else begin
                  idle_cnt <= '0;
               end
            end
            START: begin
               if (rx_cnt == CNT_W'(HALF-1)) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? IDLE : DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            DATA: begin
               if (rx_cnt == CNT_W'(CLK_DIV-1)) begin
                  rx_cnt <= '0;
                  rx_sr  <= {rx_s2, rx_sr[7:1]};
                  if (rx_bit == 3'd7) rx_state <= STOP;
                  else                rx_bit   <= rx_bit + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            STOP: begin
               if (rx_cnt == CNT_W'(CLK_DIV-1)) begin
                  rx_cnt   <= '0;
                  rx_state <= IDLE;
                  if (rx_s2) begin
                     shadow <= shadow_nxt;
                     if (rx_idx == CIDX_W'(NUM_CMD_BYTES-1)) begin
                        rx_idx <= '0;
                        // A completion overrides a same-cycle clear.
                        if (!cmd_rdy || clr_cmd_rdy) begin
                           cmd     <= shadow_nxt;
                           cmd_rdy <= 1'b1;
                        end else begin
                           ovr_err <= 1'b1;
                        end
                     end else begin
                        rx_idx <= rx_idx + 1'b1;
                     end
                  end else begin
                     frm_err <= 1'b1;
                     rx_idx  <= '0;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= IDLE;
         endcase
      end
   end

   state_t            tx_state;
   logic [CNT_W-1:0]  tx_cnt;
   logic [2:0]        tx_bit;
   logic [6:0]        tx_sh;
   logic [RSP_W-1:0]  tx_word;
   logic [RIDX_W-1:0] tx_idx;

   // The byte being sent is always the top byte of tx_word; later bytes shift up into place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         tx_word  <= '0;
         tx_idx   <= '0;
         TX       <= 1'b1;
         tx_busy  <= 1'b0;
         rsp_done <= 1'b0;
      end else begin
         rsp_done <= 1'b0;
         case (tx_state)
            IDLE: begin
               if (snd_rsp) begin
                  tx_word  <= rsp;
                  tx_idx   <= '0;
                  tx_busy  <= 1'b1;
                  tx_cnt   <= '0;
                  TX       <= 1'b0;
                  tx_state <= START;
               end
            end
            START: begin
               if (tx_cnt == CNT_W'(CLK_DIV-1)) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  TX       <= tx_word[RSP_W-8];
                  tx_sh    <= tx_word[RSP_W-1:RSP_W-7];
                  tx_state <= DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tx_cnt == CNT_W'(CLK_DIV-1)) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     TX       <= 1'b1;
                     tx_state <= STOP;
                  end else begin
                     TX     <= tx_sh[0];
                     tx_sh  <= {1'b0, tx_sh[6:1]};
                     tx_bit <= tx_bit + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            STOP: begin
               if (tx_cnt == CNT_W'(CLK_DIV-1)) begin
                  tx_cnt <= '0;
                  if (tx_idx == RIDX_W'(NUM_RSP_BYTES-1)) begin
                     tx_busy  <= 1'b0;
                     rsp_done <= 1'b1;
                     tx_state <= IDLE;
                  end else begin
                     tx_idx   <= tx_idx + 1'b1;
                     tx_word  <= tx_word << 8;
                     TX       <= 1'b0;
                     tx_state <= START;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_comm_param.sv
// Bench for uart_cmd_comm_param: serial byte driver, loopback, and a frame/queue level
// model of the TX waveform and received commands, compared on every falling clock edge.
module tb_uart_cmd_comm_param;

   localparam int CD       = 16;
   localparam int NB       = 3;
   localparam int F        = 10*NB*CD;
   localparam int TO       = 16*CD;
   localparam int DONE_OFS = 3 + CD/2 + 9*CD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_drv = 1'b1, rx1_drv = 1'b1, loop_en = 1'b0;
   logic        clr_cmd_rdy = 1'b0, clr1 = 1'b0, snd_rsp = 1'b0;
   logic [23:0] rsp = '0;
   logic        rx_line, tx, cmd_rdy, tx_busy, rsp_done, frm_err, ovr_err, rx_resync;
   logic [23:0] cmd;
   logic        tx1, cmd_rdy1, tx_busy1, rsp_done1, frm_err1, ovr_err1, rx_resync1;
   logic [7:0]  cmd1;

   assign rx_line = loop_en ? tx : rx_drv;

   uart_cmd_comm_param #(.CLK_DIV(CD), .NUM_CMD_BYTES(NB), .NUM_RSP_BYTES(NB), .TIMEOUT_BAUDS(16)) dut (
      .clk(clk), .rst(rst), .RX(rx_line), .TX(tx), .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(cmd_rdy),
      .cmd(cmd), .snd_rsp(snd_rsp), .rsp(rsp), .tx_busy(tx_busy), .rsp_done(rsp_done),
      .frm_err(frm_err), .ovr_err(ovr_err), .rx_resync(rx_resync));

   uart_cmd_comm_param #(.CLK_DIV(CD), .NUM_CMD_BYTES(1), .NUM_RSP_BYTES(1), .TIMEOUT_BAUDS(16)) dut1 (
      .clk(clk), .rst(rst), .RX(rx1_drv), .TX(tx1), .clr_cmd_rdy(clr1), .cmd_rdy(cmd_rdy1),
      .cmd(cmd1), .snd_rsp(1'b0), .rsp(8'h00), .tx_busy(tx_busy1), .rsp_done(rsp_done1),
      .frm_err(frm_err1), .ovr_err(ovr_err1), .rx_resync(rx_resync1));

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int cyc = 0;
   int obs_frm = 0, obs_ovr = 0, obs_rsy = 0, obs_done = 0;
   int e_frm = 0, e_ovr = 0, e_rsy = 0;

   // Model state: TX frame in flight, received-byte queue, command register.
   bit          m_tx_on = 1'b0;
   int          m_tx_start = 0;
   logic [23:0] m_tx_word = '0;
   logic [7:0]  m_q[$];
   logic [23:0] m_cmd = '0;
   bit          m_rdy = 1'b0;
   bit          rx_settling = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit ok, input bit clr_same);
      if (!ok) begin
         e_frm++;
         m_q.delete();
      end else begin
         m_q.push_back(b);
         if (m_q.size() == NB) begin
            if (!m_rdy || clr_same) begin
               m_cmd = {m_q[0], m_q[1], m_q[2]};
               m_rdy = 1'b1;
            end else begin
               e_ovr++;
            end
            m_q.delete();
         end
      end
   endtask

   task automatic model_idle(input int clocks);
      if (m_q.size() != 0 && clocks >= TO) begin
         e_rsy++;
         m_q.delete();
      end
   endtask

   // TX model: accepts a request only when no frame is in flight.
   always @(posedge clk) begin
      cyc++;
      if (rst) m_tx_on = 1'b0;
      else if (snd_rsp && (!m_tx_on || (cyc - 1 - m_tx_start) >= F)) begin
         m_tx_on    = 1'b1;
         m_tx_start = cyc;
         m_tx_word  = rsp;
      end
   end

   always @(negedge clk) begin : cmp
      int   k, pos;
      logic etx, ebusy, edone;
      k = cyc - m_tx_start;
      etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
      if (!rst && m_tx_on && k <= F) begin
         if (k == F) edone = 1'b1;
         else begin
            ebusy = 1'b1;
            pos = (k / CD) % 10;
            if (pos == 0)      etx = 1'b0;
            else if (pos == 9) etx = 1'b1;
            else               etx = m_tx_word[8*(NB-1-k/(10*CD)) + pos - 1];
         end
      end
      check("tx_line", tx, etx);
      check("tx_busy", tx_busy, ebusy);
      check("rsp_done", rsp_done, edone);
      if (!rx_settling) begin
         check("cmd", cmd, m_cmd);
         check("cmd_rdy", cmd_rdy, m_rdy);
      end
      if (frm_err)   obs_frm++;
      if (ovr_err)   obs_ovr++;
      if (rx_resync) obs_rsy++;
      if (rsp_done)  obs_done++;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop, input bit to1, input bit clr_done);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int c = 0; c < 10*CD; c++) begin
         tick();
         if (c % CD == 0) begin
            if (to1) rx1_drv = fr[c/CD];
            else     rx_drv  = fr[c/CD];
         end
         if (c == 9*CD && !to1) rx_settling = 1'b1;
         clr_cmd_rdy = clr_done && (c == DONE_OFS - 1);
      end
      tick();
      if (to1) rx1_drv = 1'b1;
      else     rx_drv  = 1'b1;
      if (!to1) begin
         repeat (4) tick();
         model_byte(b, stop, clr_done);
         rx_settling = 1'b0;
      end
   endtask

   task automatic send3(input logic [23:0] w);
      for (int i = 0; i < NB; i++) send_byte(w[8*(NB-1-i) +: 8], 1'b1, 1'b0, 1'b0);
   endtask

   task automatic clr;
      tick();
      clr_cmd_rdy = 1'b1;
      rx_settling = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0;
      m_rdy = 1'b0;
      rx_settling = 1'b0;
   endtask

   task automatic loopback(input logic [23:0] w, input bit poke);
      int t0;
      bit got;
      got = 1'b0;
      loop_en = 1'b1;
      rx_settling = 1'b1;
      tick();
      rsp = w;
      snd_rsp = 1'b1;
      tick();
      snd_rsp = 1'b0;
      rsp = ~w;
      t0 = cyc;
      for (int i = 0; i < F + 40; i++) begin
         tick();
         if (poke && i == 100) begin
            rsp = 24'hFFFFFF;
            snd_rsp = 1'b1;
         end else begin
            snd_rsp = 1'b0;
         end
         if (rsp_done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("rsp_done_timeout", 32'd0, 32'd1);
      else      check("rsp_done_latency", cyc - t0, F);
      check("tx_busy_after", tx_busy, 1'b0);
      repeat (CD) tick();
      for (int i = 0; i < NB; i++) model_byte(w[8*(NB-1-i) +: 8], 1'b1, 1'b0);
      rx_settling = 1'b0;
      loop_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      repeat (4) tick();
      check("rst_tx", tx, 1'b1);
      check("rst_cmd", cmd, 24'h0);
      check("rst_cmd_rdy", cmd_rdy, 1'b0);
      check("rst_tx_busy", tx_busy, 1'b0);

      loopback(24'h000000, 1'b0);
      check("lb0_cmd", cmd, 24'h000000);
      check("lb0_rdy", cmd_rdy, 1'b1);
      clr();
      loopback(24'h123456, 1'b0);
      check("lb1_cmd", cmd, 24'h123456);
      check("lb1_rdy", cmd_rdy, 1'b1);

      clr();
      send3(24'hA5B6C7);
      send3(24'h010203);
      check("ovr_cmd_held", cmd, 24'hA5B6C7);
      check("ovr_count", obs_ovr, 1);
      clr();
      send3(24'h010203);
      check("ovr_clr_cmd", cmd, 24'h010203);
      check("ovr_count_after", obs_ovr, 1);

      clr();
      send_byte(8'h55, 1'b0, 1'b0, 1'b0);
      check("frm_count", obs_frm, 1);
      check("frm_no_rdy", cmd_rdy, 1'b0);
      send3(24'h112233);
      check("frm_next_cmd", cmd, 24'h112233);

      clr();
      send_byte(8'hDE, 1'b1, 1'b0, 1'b0);
      send_byte(8'hAD, 1'b1, 1'b0, 1'b0);
      repeat (20*CD) tick();
      model_idle(20*CD);
      send3(24'h112233);
      check("to_cmd", cmd, 24'h112233);
      check("to_resync_count", obs_rsy, 1);
      check("to_rdy", cmd_rdy, 1'b1);

      clr();
      tick();
      rx_drv = 1'b0;
      repeat (CD/4) tick();
      rx_drv = 1'b1;
      repeat (2*CD) tick();
      send3(24'h778899);
      check("glitch_cmd", cmd, 24'h778899);
      send_byte(8'h44, 1'b1, 1'b0, 1'b0);
      send_byte(8'h55, 1'b1, 1'b0, 1'b0);
      send_byte(8'h66, 1'b1, 1'b0, 1'b1);
      check("clr_same_cmd", cmd, 24'h445566);
      check("clr_same_rdy", cmd_rdy, 1'b1);
      check("clr_same_no_ovr", obs_ovr, 1);

      clr();
      loopback(24'hABCDEF, 1'b1);
      check("busy_poke_cmd", cmd, 24'hABCDEF);
      check("busy_poke_done", obs_done, 3);

      send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
      check("one_cmd_a", cmd1, 8'h3C);
      check("one_rdy_a", cmd_rdy1, 1'b1);
      tick(); clr1 = 1'b1; tick(); clr1 = 1'b0;
      check("one_clr", cmd_rdy1, 1'b0);
      send_byte(8'hC3, 1'b1, 1'b1, 1'b0);
      check("one_cmd_b", cmd1, 8'hC3);
      check("one_rdy_b", cmd_rdy1, 1'b1);

      clr();
      loop_en = 1'b1;
      rx_settling = 1'b1;
      tick();
      rsp = 24'h123456;
      snd_rsp = 1'b1;
      tick();
      snd_rsp = 1'b0;
      repeat (15*CD) tick();
      rst = 1'b1;
      m_cmd = '0;
      m_rdy = 1'b0;
      m_q.delete();
      rx_settling = 1'b0;
      #1;
      check("mid_rst_tx", tx, 1'b1);
      check("mid_rst_busy", tx_busy, 1'b0);
      check("mid_rst_cmd", cmd, 24'h0);
      check("mid_rst_rdy", cmd_rdy, 1'b0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (3*CD) tick();
      check("mid_rst_no_done", obs_done, 3);
      loopback(24'h123456, 1'b0);
      check("post_rst_cmd", cmd, 24'h123456);
      check("post_rst_rdy", cmd_rdy, 1'b1);
      check("post_rst_done", obs_done, 4);

      check("final_frm", obs_frm, e_frm);
      check("final_ovr", obs_ovr, e_ovr);
      check("final_rsy", obs_rsy, e_rsy);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
